// File: rtl/bcd2bin_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : bcd2bin_pkg                                                      |
// | Purpose : Shared types and constants for the BCD-to-binary converter:      |
// |           FSM state encoding, per-nibble adjust constants and a helper     |
// |           that returns the narrowest binary width able to hold a           |
// |           DIGITS-digit decimal value.                                      |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package bcd2bin_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Reverse double-dabble: after a right shift a nibble holding >= 8 was a
   // decimal digit whose LSB crossed in from the digit above (worth 10/2 = 5,
   // but 8 in binary), so 3 is taken back off.
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
   localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;
   localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

   // Smallest w with 2^w >= 10^digits (valid for digits up to 18).
   function automatic int min_bin_w(input int digits);
      longint unsigned pow10;
      int              w;
      bit              found;
      pow10 = 1;
      for (int i = 0; i < digits; i++) begin
         pow10 = pow10 * 10;
      end
      w     = 0;
      found = 1'b0;
      for (int j = 0; j < 64; j++) begin
         if (!found && ((64'd1 << j) >= pow10)) begin
            w     = j;
            found = 1'b1;
         end
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_nibble_adjust.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_nibble_adjust                                                |
// | Purpose : Combinational reverse double-dabble correction for one nibble:   |
// |           output = input - 3 when input >= 8, otherwise input unchanged.   |
// | Ports   : nib_in  [3:0]  post-shift nibble                                 |
// |           nib_out [3:0]  corrected nibble                                  |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bcd_nibble_adjust
   import bcd2bin_pkg::*;
(
   input  logic [3:0] nib_in,
   output logic [3:0] nib_out
);

   always_comb begin
      nib_out = nib_in;
      if (nib_in >= BCD_ADJ_THRESH) begin
         nib_out = nib_in - BCD_ADJ_SUB;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_to_binary                                                    |
// | Purpose : Sequential packed-BCD to unsigned binary converter using         |
// |           reverse double-dabble (one right shift plus per-nibble           |
// |           subtract-3 per cycle, BIN_W cycles per conversion).              |
// | Params  : DIGITS - number of BCD digits at the input (default 3)           |
// |           BIN_W  - binary output width, 2^BIN_W >= 10^DIGITS (default 10)  |
// | Ports   : clk    in   clock, rising edge                                   |
// |           rst_n  in   asynchronous active-low reset                        |
// |           start  in   conversion request, sampled in IDLE or DONE          |
// |           bcd    in   packed BCD, digit 0 in [3:0]                         |
// |           busy   out  conversion in progress                               |
// |           done   out  one-cycle completion pulse                           |
// |           bin    out  binary result, held until next completion            |
// |           err    out  invalid-digit flag, valid with done                  |
// | Macro   : BCD2BIN_DIGIT_CHECK_EN - when defined, an input nibble > 9 at    |
// |           accept skips the shift phase and reports err=1, bin=0.           |
// |           When undefined err is tied low and no check is made.             |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bcd_to_binary
   import bcd2bin_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin,
   output logic                  err
);

   localparam int          SR_W     = 4*DIGITS + BIN_W;
   localparam int          CNT_W    = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   generate
      if (BIN_W < min_bin_w(DIGITS)) begin : g_param_check
         $error("bcd_to_binary: BIN_W too small for DIGITS");
      end
   endgenerate

   state_t             r_state;
   state_t             w_next_state;
   logic [SR_W-1:0]    r_sr;
   logic [SR_W-1:0]    w_shifted;
   logic [SR_W-1:0]    w_adj;
   logic [CNT_W-1:0]   r_cnt;
   logic [BIN_W-1:0]   r_bin;
   logic               w_accept;
   logic               w_last;
   logic               w_invalid;

   // ---------------------------------------------------------------------
   // Datapath: shift right, then correct every BCD nibble in parallel.
   // The binary field below the BCD nibbles passes through untouched.
   // ---------------------------------------------------------------------
   assign w_shifted = r_sr >> 1;
   assign w_adj[BIN_W-1:0] = w_shifted[BIN_W-1:0];

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_nibble
         bcd_nibble_adjust u_adj (
            .nib_in  (w_shifted[BIN_W + 4*g +: 4]),
            .nib_out (w_adj[BIN_W + 4*g +: 4])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Optional input digit check
   // ---------------------------------------------------------------------
`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic r_err;

   always_comb begin
      w_invalid = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] > BCD_MAX_DIGIT) begin
            w_invalid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= w_invalid;
      end
   end

   assign err = r_err;
`else
   assign w_invalid = 1'b0;
   assign err       = 1'b0;
`endif

   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_cnt == CNT_LAST);

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = w_invalid ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_last) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               w_next_state = w_invalid ? DONE : SHIFT;
            end else begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Shift register, iteration counter and result register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr  <= '0;
         r_cnt <= '0;
         r_bin <= '0;
      end else if (w_accept) begin
         r_sr  <= {bcd, {BIN_W{1'b0}}};
         r_cnt <= '0;
         if (w_invalid) begin
            r_bin <= '0;
         end
      end else if (r_state == SHIFT) begin
         r_sr  <= w_adj;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_bin <= w_adj[BIN_W-1:0];
         end
      end
   end

   assign bin = r_bin;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bcd_to_binary                                                 |
// | Purpose : Directed self-checking bench for bcd_to_binary (DIGITS=3,        |
// |           BIN_W=10): reset state, single conversions, back-to-back         |
// |           launch, async abort, optional digit check and a full sweep.      |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bcd_to_binary;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [11:0]       bcd;
   logic              busy;
   logic              done;
   logic [BIN_W-1:0]  bin;
   logic              err;

   int n_checks = 0;
   int n_errors = 0;

   bcd_to_binary #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bcd   (bcd),
      .busy  (busy),
      .done  (done),
      .bin   (bin),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] d2, d1, d0;
      d2 = 4'(v / 100);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
      return {d2, d1, d0};
   endfunction

   // Launch one conversion and follow it to done. Latency k counts negedges
   // after the accepting edge, so k=10 means done was raised by edge 10.
   task automatic run_conv(input string tag, input logic [11:0] b,
                           input int exp_bin, input int exp_err,
                           input int exp_lat);
      int lat;
      int busy_n;
      int overlap;
      lat     = -1;
      busy_n  = 0;
      overlap = 0;
      @(negedge clk);
      bcd   = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy && done) overlap++;
         if (done) begin
            lat = k;
            break;
         end
         if (busy) busy_n++;
      end
      chk_val({tag, "_latency"}, lat, exp_lat);
      chk_val({tag, "_busy_cycles"}, busy_n, exp_lat);
      chk_val({tag, "_busy_done_overlap"}, overlap, 0);
      chk_val({tag, "_bin"}, bin, exp_bin);
      chk_val({tag, "_err"}, err, exp_err);
   endtask

   initial begin
      int done_cnt;
      int first_k;
      int second_k;
      int sweep_bad;

      rst_n = 1'b0;
      start = 1'b0;
      bcd   = '0;

      // Reset state
      #12;
      chk_val("rst_busy", busy, 0);
      chk_val("rst_done", done, 0);
      chk_val("rst_bin",  bin,  0);
      chk_val("rst_err",  err,  0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic conversions
      run_conv("c127", 12'h127, 127, 0, 10);
      run_conv("c999", 12'h999, 999, 0, 10);
      run_conv("c000", 12'h000, 0,   0, 10);

`ifdef BCD2BIN_DIGIT_CHECK_EN
      begin
         int lat;
         lat = -1;
         @(negedge clk);
         bcd   = 12'h1A3;
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
               lat = k;
               break;
            end
         end
         chk_val("inv_fast_done", (lat >= 0 && lat <= 1), 1);
         chk_val("inv_err", err, 1);
         chk_val("inv_bin", bin, 0);
      end
      run_conv("c042", 12'h042, 42, 0, 10);
`endif

      // Back-to-back: start held through SHIFT and into DONE
      done_cnt = 0;
      first_k  = -1;
      second_k = -1;
      @(negedge clk);
      bcd   = 12'h555;
      start = 1'b1;
      @(posedge clk);
      #1 bcd = 12'h111;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               first_k = k;
               chk_val("b2b_first_bin", bin, 555);
            end else if (done_cnt == 2) begin
               second_k = k;
               chk_val("b2b_second_bin", bin, 111);
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk_val("b2b_done_count", done_cnt, 2);
      chk_val("b2b_first_edge", first_k, 10);
      chk_val("b2b_second_edge", second_k, 21);

      // Asynchronous abort mid-conversion
      repeat (2) @(negedge clk);
      bcd   = 12'h876;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk_val("abort_busy_before", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk_val("abort_busy", busy, 0);
      chk_val("abort_done", done, 0);
      chk_val("abort_bin",  bin,  0);
      chk_val("abort_err",  err,  0);
      done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (k == 2) rst_n = 1'b1;
      end
      chk_val("abort_no_done", done_cnt, 0);
      run_conv("c876", 12'h876, 876, 0, 10);

      // Full sweep of valid 3-digit inputs
      sweep_bad = n_errors;
      for (int v = 0; v < 1000; v++) begin
         run_conv($sformatf("sweep%0d", v), to_bcd(v), v, 0, 10);
      end
      chk_val("sweep_new_errors", n_errors - sweep_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
